rs_syndrome_engine: RTL

//  Streaming Reed-Solomon syndrome generator over GF(2^M); parametrised successor of the fixed 21-bit syndrome calculator.

---
 rtl/rs_syndrome_engine.sv | 109 ++++++++++
 1 files changed

// File: rtl/rs_syndrome_engine.sv
// Streaming Reed-Solomon syndrome generator over GF(2^M): Horner accumulation of
// 2T syndromes, one received symbol per cycle, results handed off over valid/ready.
module rs_syndrome_engine #(
  parameter int unsigned M         = 3,
  parameter int unsigned N         = 7,
  parameter int unsigned T         = 2,
  parameter logic [M:0]  PRIM_POLY = 'hB,
  parameter int unsigned FCR       = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [M-1:0]       in_sym,
  output logic               synd_valid,
  input  logic               synd_ready,
  output logic [2*T*M-1:0]   syndromes,
  output logic               err_free
);

  localparam int unsigned NS = 2 * T;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Multiply by alpha^k as k repeated xtime steps; k is constant per syndrome lane.
  function automatic logic [M-1:0] mul_alpha_k(input logic [M-1:0] a, input int unsigned k);
    logic [M-1:0] r;
    r = a;
    for (int unsigned i = 0; i < k; i++) begin
      r = r[M-1] ? ((r << 1) ^ PRIM_POLY[M-1:0]) : (r << 1);
    end
    return r;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          sym_cnt_q, sym_cnt_d;
  logic [NS-1:0][M-1:0]   acc_q, acc_d, acc_step;
  logic                   accept;

  assign in_ready   = (state_q != S_DONE);
  assign accept     = in_valid && in_ready;
  assign synd_valid = (state_q == S_DONE);
  assign syndromes  = synd_valid ? acc_q : '0;
  assign err_free   = synd_valid && (acc_q == '0);

  always_comb begin
    acc_step = '0;
    for (int unsigned j = 0; j < NS; j++) begin
      acc_step[j] = mul_alpha_k(acc_q[j], FCR + j) ^ in_sym;
    end
  end

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    acc_d     = acc_q;
    if (abort) begin
      state_d   = S_IDLE;
      sym_cnt_d = '0;
      acc_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            for (int unsigned j = 0; j < NS; j++) acc_d[j] = in_sym;
            sym_cnt_d = CW'(1);
            state_d   = (N == 1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_d     = acc_step;
            sym_cnt_d = sym_cnt_q + CW'(1);
            if (sym_cnt_q == CW'(N - 1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (synd_ready) begin
            state_d   = S_IDLE;
            sym_cnt_d = '0;
            acc_d     = '0;
          end
        end
        default: begin
          state_d   = S_IDLE;
          sym_cnt_d = '0;
          acc_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sym_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      acc_q     <= acc_d;
    end
  end

endmodule
